// File: rtl/seq_mult_unit_if.sv
// Operand/result bundle between the ALU-side caller and the MULT unit.
// Latency: none, plain wires.
// Backpressure: none; the caller watches busy/done before issuing start.
interface seq_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, mcand, mplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH), optional signed mode.
// Latency: WIDTH cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is only taken in IDLE/DONE; requests during RUN are dropped.
module seq_mult_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  seq_mult_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   p_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  logic                 accept;
  logic                 sgn;
  logic                 last;
  logic [WIDTH-1:0]     mcand_mag;
  logic [WIDTH-1:0]     mplier_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_nxt;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign sgn    = bus.signed_mode & SIGNED_EN;

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign mcand_mag  = (sgn && bus.mcand[WIDTH-1])  ? -bus.mcand  : bus.mcand;
  assign mplier_mag = (sgn && bus.mplier[WIDTH-1]) ? -bus.mplier : bus.mplier;

  // Add into the upper half with the carry kept, then shift the whole thing right.
  assign sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, m_reg} : '0);
  assign p_nxt = {sum, p_reg[WIDTH-1:1]};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      m_reg   <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      p_reg <= {{WIDTH{1'b0}}, mplier_mag};
      m_reg <= mcand_mag;
      cnt   <= '0;
      neg   <= sgn & (bus.mcand[WIDTH-1] ^ bus.mplier[WIDTH-1]);
    end else if (state == RUN) begin
      p_reg <= p_nxt;
      cnt   <= cnt + 1'b1;
      if (last) product <= neg ? -p_nxt : p_nxt;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: three instances (32-bit signed-capable,
// 32-bit with signed mode disabled, 8-bit), scoreboard queues fed at issue and
// drained on each done pulse.
module tb_seq_mult_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_unit_if #(.WIDTH(32)) ia ();
  seq_mult_unit_if #(.WIDTH(32)) ib ();
  seq_mult_unit_if #(.WIDTH(8))  ic ();

  seq_mult_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  seq_mult_unit #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  seq_mult_unit #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  logic [63:0] qa_prod[$];
  int          qa_lat[$];
  logic [63:0] qb_prod[$];
  int          qb_lat[$];
  logic [15:0] qc_prod[$];
  int          qc_lat[$];
  int          busy_a = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the main instance: product, latency and busy duration.
  always @(negedge clk) begin
    if (ia.busy) busy_a++;
    if (ia.done) begin
      if (qa_prod.size() == 0) begin
        check("a_spurious_done", 1, 0);
      end else begin
        check("a_product", ia.product, qa_prod.pop_front());
        check("a_latency", cyc - qa_lat.pop_front(), 32);
        check("a_busy_cycles", busy_a, 32);
      end
      busy_a = 0;
    end else if (!ia.busy) begin
      busy_a = 0;
    end
  end

  // Scoreboard for the signed-disabled instance.
  always @(negedge clk) begin
    if (ib.done) begin
      if (qb_prod.size() == 0) begin
        check("b_spurious_done", 1, 0);
      end else begin
        check("b_product", ib.product, qb_prod.pop_front());
        check("b_latency", cyc - qb_lat.pop_front(), 32);
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (ic.done) begin
      if (qc_prod.size() == 0) begin
        check("c_spurious_done", 1, 0);
      end else begin
        check("c_product", {48'd0, ic.product}, {48'd0, qc_prod.pop_front()});
        check("c_latency", cyc - qc_lat.pop_front(), 8);
      end
    end
  end

  // All issue tasks are entered at a negedge and return at the next negedge,
  // leaving scrambled operands on the bus to show they are only sampled with start.
  task automatic issue_a(input logic [31:0] x, input logic [31:0] y, input logic sm,
                         input logic [63:0] exp);
    ia.start = 1'b1; ia.signed_mode = sm; ia.mcand = x; ia.mplier = y;
    qa_prod.push_back(exp);
    qa_lat.push_back(cyc + 1);
    @(negedge clk);
    ia.start = 1'b0; ia.signed_mode = ~sm; ia.mcand = $urandom; ia.mplier = $urandom;
  endtask

  task automatic issue_b(input logic [31:0] x, input logic [31:0] y, input logic sm,
                         input logic [63:0] exp);
    ib.start = 1'b1; ib.signed_mode = sm; ib.mcand = x; ib.mplier = y;
    qb_prod.push_back(exp);
    qb_lat.push_back(cyc + 1);
    @(negedge clk);
    ib.start = 1'b0; ib.mcand = $urandom; ib.mplier = $urandom;
  endtask

  task automatic issue_c(input logic [7:0] x, input logic [7:0] y, input logic sm,
                         input logic [15:0] exp);
    ic.start = 1'b1; ic.signed_mode = sm; ic.mcand = x; ic.mplier = y;
    qc_prod.push_back(exp);
    qc_lat.push_back(cyc + 1);
    @(negedge clk);
    ic.start = 1'b0; ic.signed_mode = ~sm; ic.mcand = 8'($urandom); ic.mplier = 8'($urandom);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!ia.done && n < 200) begin @(negedge clk); n++; end
    if (!ia.done) check("a_timeout", 0, 1);
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!ib.done && n < 200) begin @(negedge clk); n++; end
    if (!ib.done) check("b_timeout", 0, 1);
  endtask

  task automatic wait_done_c();
    int n = 0;
    while (!ic.done && n < 200) begin @(negedge clk); n++; end
    if (!ic.done) check("c_timeout", 0, 1);
  endtask

  initial begin
    ia.start = 1'b0; ia.signed_mode = 1'b0; ia.mcand = '0; ia.mplier = '0;
    ib.start = 1'b0; ib.signed_mode = 1'b0; ib.mcand = '0; ib.mplier = '0;
    ic.start = 1'b0; ic.signed_mode = 1'b0; ic.mcand = '0; ic.mplier = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", ia.busy, 0);
    check("reset_done", ia.done, 0);
    check("reset_product", ia.product, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned basics, carry path, signed cases, zero operand.
    issue_a(32'd12, 32'd8, 1'b0, 64'd96);
    wait_done_a();
    @(negedge clk);
    check("a_done_one_cycle", ia.done, 0);
    check("a_product_held", ia.product, 64'd96);
    issue_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    wait_done_a(); @(negedge clk);
    issue_a(-32'sd3, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done_a(); @(negedge clk);
    issue_a(-32'sd3, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
    wait_done_a(); @(negedge clk);
    issue_a(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait_done_a(); @(negedge clk);
    issue_a(32'd0, -32'sd7, 1'b1, 64'd0);
    wait_done_a(); @(negedge clk);

    // Start during RUN is ignored; start in the DONE cycle chains back-to-back.
    issue_a(32'd1000, 32'd3000, 1'b0, 64'd3000000);
    repeat (8) @(negedge clk);
    ia.start = 1'b1; ia.mcand = 32'd7; ia.mplier = 32'd9;
    @(negedge clk);
    ia.start = 1'b0;
    wait_done_a();
    issue_a(32'h1234_5678, 32'h10, 1'b0, 64'h1_2345_6780);
    check("a_b2b_busy", ia.busy, 1);
    check("a_b2b_product_held", ia.product, 64'd3000000);
    wait_done_a(); @(negedge clk);

    // Reset mid-run aborts immediately with no done pulse.
    issue_a(32'd5, 32'd6, 1'b0, 64'd30);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", ia.busy, 0);
    check("abort_done", ia.done, 0);
    check("abort_product", ia.product, 0);
    qa_prod.delete();
    qa_lat.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", ia.done, 0);
    issue_a(32'd123, 32'd456, 1'b1, 64'd56088);
    wait_done_a(); @(negedge clk);

    // Signed mode disabled: signed_mode is ignored.
    issue_b(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait_done_b(); @(negedge clk);
    issue_b(-32'sd3, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1);
    wait_done_b(); @(negedge clk);

    // 8-bit instance.
    issue_c(8'd255, 8'd255, 1'b0, 16'hFE01);
    wait_done_c(); @(negedge clk);
    issue_c(8'h80, 8'd127, 1'b1, 16'hC080);
    wait_done_c(); @(negedge clk);
    issue_c(8'hFF, 8'hFF, 1'b1, 16'h0001);
    wait_done_c(); @(negedge clk);

    check("a_queue_empty", qa_prod.size(), 0);
    check("b_queue_empty", qb_prod.size(), 0);
    check("c_queue_empty", qc_prod.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
